// File: rtl/addsub_div_ctrl_pkg.sv
// Shared definitions for the sequential restoring divider: default operand
// width, controller state encoding and the iteration counter width.
package addsub_div_ctrl_pkg;

    // Default operand / result width; the divider runs one iteration per bit.
    localparam int DEF_WIDTH = 4;

    // State encodings, kept as named constants so they can be compared in
    // waveforms and reused by anything that decodes the state register.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ITER = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        ITER = ST_ITER,
        DONE = ST_DONE
    } state_e;

    // Counter width for an iteration count of w; never narrower than one bit
    // so a degenerate width still yields a legal register.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    localparam int DEF_CNT_W = cnt_width(DEF_WIDTH);

endpackage

// File: rtl/addsub_div_ctrl_addsub_rca.sv
// Ripple-carry adder/subtractor. With sub=1 it forms a + ~b + 1, so cout is
// the "no borrow" flag of an unsigned a - b.
module addsub_rca #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] s,
    output logic             cout
);

    logic [WIDTH-1:0] bx;
    logic             carry;

    // Bit-serial ripple: the carry-in of bit 0 is the subtract flag itself.
    always_comb begin
        bx    = b ^ {WIDTH{sub}};
        carry = sub;
        s     = '0;
        for (int i = 0; i < WIDTH; i++) begin
            s[i]  = a[i] ^ bx[i] ^ carry;
            carry = (a[i] & bx[i]) | (carry & (a[i] ^ bx[i]));
        end
        cout = carry;
    end

endmodule

// File: rtl/addsub_div_ctrl.sv
// Sequential unsigned restoring divider. One shared adder/subtractor does a
// single trial subtraction per clock; this controller owns load, shift,
// restore, counting and result presentation.
module addsub_div_ctrl
    import addsub_div_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = cnt_width(WIDTH);

    state_e           state_q;
    logic [WIDTH-1:0] d_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] r_q;
    logic [CW-1:0]    cnt_q;
    logic             dz_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] quot_q;
    logic [WIDTH-1:0] rem_q;
    logic             dbz_q;

    logic [WIDTH:0]   trial_d;
    logic [WIDTH-1:0] diff_d;
    logic             cout_d;
    logic             ge_d;
    logic [WIDTH-1:0] r_step_d;
    logic [WIDTH-1:0] q_step_d;

    // The only arithmetic in the block: trial subtraction of the divisor
    // from the low bits of the shifted partial remainder.
    addsub_rca #(
        .WIDTH (WIDTH)
    ) u_addsub (
        .a    (trial_d[WIDTH-1:0]),
        .b    (d_q),
        .sub  (1'b1),
        .s    (diff_d),
        .cout (cout_d)
    );

    // One restoring step: shift the next dividend bit into the remainder,
    // keep the difference if it did not borrow, and shift the quotient bit in.
    // The extra top bit of the trial value covers remainders that overflow
    // WIDTH bits after the shift; in that case the subtraction always fits.
    always_comb begin
        trial_d  = {r_q, q_q[WIDTH-1]};
        ge_d     = trial_d[WIDTH] | cout_d;
        r_step_d = ge_d ? diff_d : trial_d[WIDTH-1:0];
        q_step_d = {q_q[WIDTH-2:0], ge_d};
    end

    // Controller and datapath registers. A zero divisor still spends one
    // cycle in ITER (with the datapath frozen) so that its done pulse lands
    // one edge after acceptance; the dividend parked in q_q becomes the
    // remainder. Results are loaded on the edge into DONE so they are valid
    // while done is high and stay put until the next accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            d_q     <= '0;
            q_q     <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            dz_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        d_q     <= divisor;
                        q_q     <= dividend;
                        r_q     <= '0;
                        dbz_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= ITER;
                        if (divisor == '0) begin
                            dz_q  <= 1'b1;
                            cnt_q <= '0;
                        end else begin
                            dz_q  <= 1'b0;
                            cnt_q <= CW'(WIDTH - 1);
                        end
                    end
                end
                ITER: begin
                    if (!dz_q) begin
                        r_q <= r_step_d;
                        q_q <= q_step_d;
                    end
                    if (cnt_q == '0) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        if (dz_q) begin
                            quot_q <= '1;
                            rem_q  <= q_q;
                            dbz_q  <= 1'b1;
                        end else begin
                            quot_q <= q_step_d;
                            rem_q  <= r_step_d;
                        end
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_addsub_div_ctrl.sv
// Scoreboard bench for the restoring divider: the driver queues the
// expected result and done edge for every accepted request, a monitor
// compares whenever done is seen.
module tb_addsub_div_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] dividend;
    logic [3:0] divisor;
    logic       busy;
    logic       done;
    logic [3:0] quotient;
    logic [3:0] remainder;
    logic       div_by_zero;

    typedef struct {
        int    q;
        int    r;
        int    dz;
        int    edgeN;
        string name;
    } exp_t;

    exp_t sbQ[$];
    int   edgeCnt    = 0;
    int   compared   = 0;
    int   mismatched = 0;
    bit   prevDone   = 1'b0;

    addsub_div_ctrl #(
        .WIDTH (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Edge index of the most recent rising edge.
    always @(posedge clk) edgeCnt++;

    task automatic checkOutput(input string name, input int act, input int exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Waits (bounded) at falling edges until the divider is idle.
    task automatic waitIdle();
        int n = 0;
        while (busy !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL waitIdle: busy=%0b after %0d cycles, expected 0", busy, n);
        end
    endtask

    // Presents one request at a falling edge where busy is low, queues the
    // expected response, then scrambles the operands after acceptance.
    task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b,
                                 input int expQ, input int expR, input bit hold,
                                 input string name, output int acc);
        exp_t e;
        @(negedge clk);
        waitIdle();
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        acc      = edgeCnt + 1;
        e.q      = expQ;
        e.r      = expR;
        e.dz     = (b == 4'd0) ? 1 : 0;
        e.edgeN  = acc + ((b == 4'd0) ? 1 : 4);
        e.name   = name;
        sbQ.push_back(e);
        @(negedge clk);
        dividend = ~a;
        divisor  = ~b;
        if (!hold) start = 1'b0;
    endtask

    // Monitor: every done pulse must match the oldest queued expectation and
    // must not be wider than one cycle.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (done === 1'b1) begin
                checkOutput("doneWidth", int'(prevDone), 0);
                if (sbQ.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL unexpectedDone: done=1 at edge %0d, expected no pulse", edgeCnt);
                end else begin
                    exp_t e;
                    e = sbQ.pop_front();
                    checkOutput({e.name, ".quotient"}, int'(quotient), e.q);
                    checkOutput({e.name, ".remainder"}, int'(remainder), e.r);
                    checkOutput({e.name, ".divByZero"}, int'(div_by_zero), e.dz);
                    checkOutput({e.name, ".doneEdge"}, edgeCnt, e.edgeN);
                    checkOutput({e.name, ".busyAtDone"}, int'(busy), 1);
                end
            end
            prevDone = (done === 1'b1);
        end else begin
            prevDone = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int acc;
        int n;
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = 4'd0;
        divisor  = 4'd0;
        repeat (3) @(negedge clk);
        checkOutput("reset.busy", int'(busy), 0);
        checkOutput("reset.done", int'(done), 0);
        checkOutput("reset.quotient", int'(quotient), 0);
        checkOutput("reset.remainder", int'(remainder), 0);
        checkOutput("reset.divByZero", int'(div_by_zero), 0);
        rst_n = 1'b1;

        // 13/3 with the busy window traced edge by edge.
        applyStimulus(4'd13, 4'd3, 4, 1, 1'b0, "d13_3", acc);
        for (int k = 0; k <= 5; k++) begin
            if (k > 0) @(negedge clk);
            checkOutput($sformatf("d13_3.busyEdge%0d", k), int'(busy), (k < 5) ? 1 : 0);
        end

        applyStimulus(4'd6,  4'd5,  1,  1, 1'b0, "d6_5",   acc);
        applyStimulus(4'd15, 4'd1,  15, 0, 1'b0, "d15_1",  acc);
        applyStimulus(4'd3,  4'd7,  0,  3, 1'b0, "d3_7",   acc);
        applyStimulus(4'd15, 4'd15, 1,  0, 1'b0, "d15_15", acc);
        applyStimulus(4'd0,  4'd9,  0,  0, 1'b0, "d0_9",   acc);

        // Divide by zero, then a normal division clears the flag.
        applyStimulus(4'd9, 4'd0, 15, 9, 1'b0, "d9_0", acc);
        applyStimulus(4'd8, 4'd2, 4,  0, 1'b0, "d8_2", acc);

        // A start pulse during ITER must be ignored.
        applyStimulus(4'd14, 4'd4, 3, 2, 1'b0, "d14_4", acc);
        @(negedge clk);
        start    = 1'b1;
        dividend = 4'd7;
        divisor  = 4'd7;
        @(negedge clk);
        start    = 1'b0;

        // Reset pulse in the middle of 11/2: no done, outputs cleared at once.
        @(negedge clk);
        waitIdle();
        dividend = 4'd11;
        divisor  = 4'd2;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("midReset.busy", int'(busy), 0);
        checkOutput("midReset.done", int'(done), 0);
        checkOutput("midReset.quotient", int'(quotient), 0);
        checkOutput("midReset.remainder", int'(remainder), 0);
        checkOutput("midReset.divByZero", int'(div_by_zero), 0);
        #2 rst_n = 1'b1;
        applyStimulus(4'd11, 4'd2, 5, 1, 1'b0, "d11_2", acc);

        // Every nonzero-divisor pair, start held high back to back.
        for (int a = 0; a < 16; a++) begin
            for (int b = 1; b < 16; b++) begin
                applyStimulus(4'(a), 4'(b), a / b, a % b, 1'b1,
                              $sformatf("ex%0d_%0d", a, b), acc);
            end
        end
        start = 1'b0;

        n = 0;
        while (sbQ.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        checkOutput("drain.pending", sbQ.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
